aes_sub_shift: RTL and testbench

Iterative SubBytes + ShiftRows stage (forward) or InvShiftRows + InvSubBytes stage (inverse) for the AES round datapath. It sits directly upstream of the mix-columns stage and produces the 128-bit block that mix columns consumes, using the same byte layout. Four S-box instances process one state row per cycle. A valid/ready handshake is provided on both sides.

---
 rtl/aes_sub_shift.sv | 147 ++++++++++++++
 tb/tb_aes_sub_shift.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_shift.sv
// Iterative AES SubBytes+ShiftRows (forward) / InvShiftRows+InvSubBytes (inverse) stage.
// One state row per cycle through four shared S-boxes; valid/ready on both sides.
module aes_sub_shift (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fwd_ninv_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] block_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] block_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1:0]     row;
  logic           mode_q;
  logic [127:0]   work_q;
  logic [31:0]    row_in;
  logic [31:0]    row_out;
  logic [7:0]     sub [4];
  logic           accept;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 for a != 0, and 0 for a == 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = gf_mul(a, a);
    r = t;
    for (int i = 2; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a, input logic fwd);
    return fwd ? affine(gf_inv(a)) : gf_inv(inv_affine(a));
  endfunction

  assign accept  = valid_i && ready_o;
  assign ready_o = (state == IDLE) && !rst_i;
  assign valid_o = (state == DONE);

  // Row select, substitution and row rotation for the current row
  always_comb begin
    row_in  = 32'h0;
    row_out = 32'h0;
    case (row)
      2'd0:    row_in = work_q[127:96];
      2'd1:    row_in = work_q[95:64];
      2'd2:    row_in = work_q[63:32];
      default: row_in = work_q[31:0];
    endcase
    for (int c = 0; c < 4; c++) begin
      sub[c] = sbox(row_in[31-8*c -: 8], mode_q);
    end
    // Substitution is bytewise, so rotating after it equals rotating before it
    case (row)
      2'd0:    row_out = {sub[0], sub[1], sub[2], sub[3]};
      2'd1:    row_out = mode_q ? {sub[1], sub[2], sub[3], sub[0]}
                                : {sub[3], sub[0], sub[1], sub[2]};
      2'd2:    row_out = {sub[2], sub[3], sub[0], sub[1]};
      default: row_out = mode_q ? {sub[3], sub[0], sub[1], sub[2]}
                                : {sub[1], sub[2], sub[3], sub[0]};
    endcase
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = BUSY;
        else        state_next = IDLE;
      end
      BUSY: begin
        if (row == 2'd3) state_next = DONE;
        else             state_next = BUSY;
      end
      DONE: begin
        if (ready_i) state_next = IDLE;
        else         state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Input capture, row counter and result rows
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row     <= 2'd0;
      mode_q  <= 1'b1;
      work_q  <= 128'h0;
      block_o <= 128'h0;
    end else if (state == IDLE) begin
      if (accept) begin
        work_q <= block_i;
        mode_q <= fwd_ninv_i;
        row    <= 2'd0;
      end
    end else if (state == BUSY) begin
      row <= row + 2'd1;
      case (row)
        2'd0:    block_o[127:96] <= row_out;
        2'd1:    block_o[95:64]  <= row_out;
        2'd2:    block_o[63:32]  <= row_out;
        default: block_o[31:0]   <= row_out;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Directed self-checking bench for aes_sub_shift: FIPS-197 vectors, reset,
// backpressure, mode latching and back-to-back streaming against a table model.
module tb_aes_sub_shift;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         fwd_ninv_i;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] block_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] block_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  localparam logic [127:0] FIPS_IN  = 128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08;
  localparam logic [127:0] FIPS_OUT = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;

  aes_sub_shift dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fwd_ninv_i (fwd_ninv_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .block_i    (block_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .block_o    (block_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // S-box tables by brute-force inverse search and bitwise affine formula
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk, input logic fwd);
    logic [127:0] o;
    logic [7:0]   b;
    int           src;
    o = 128'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = fwd ? (c + r) % 4 : (c - r + 4) % 4;
        b   = blk[127-8*(4*r+src) -: 8];
        o[127-8*(4*r+c) -: 8] = fwd ? sb[b] : isb[b];
      end
    return o;
  endfunction

  // Accept one block and wait for valid_o; lat = -1 if it never arrives
  task automatic run_block(input logic [127:0] blk, input logic fwd,
                           output logic [127:0] res, output int lat);
    int k;
    lat = -1;
    k = 0;
    while (!ready_o && k < 50) begin
      @(posedge clk_i); #1;
      k++;
    end
    block_i = blk; fwd_ninv_i = fwd; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) begin
        lat = i;
        break;
      end
    end
    res = block_o;
  endtask

  task automatic release_out();
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] res;
    int lat;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; fwd_ninv_i = 1'b1; block_i = 128'h0;
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_tests++; if (block_o !== 128'h0) begin n_fail++; $display("FAIL reset_block: got %h expected 0", block_o); end
    @(negedge clk_i); rst_i = 1'b0; #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", ready_o); end
    // Mid-BUSY asynchronous reset
    block_i = FIPS_IN; fwd_ninv_i = 1'b1; valid_i = 1'b1;
    @(posedge clk_i); #1; valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #3;
    rst_i = 1'b1; #1;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", valid_o); end
    n_tests++; if (block_o !== 128'h0) begin n_fail++; $display("FAIL async_rst_block: got %h expected 0", block_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 0", ready_o); end
    @(negedge clk_i); rst_i = 1'b0; #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", ready_o); end
    run_block(128'h0, 1'b1, res, lat);
    n_tests++; if (res !== {16{8'h63}}) begin n_fail++; $display("FAIL post_rst_block: got %h expected %h", res, {16{8'h63}}); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    release_out();
  endtask

  task automatic test_forward();
    logic [127:0] res;
    int lat;
    run_block(FIPS_IN, 1'b1, res, lat);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
    n_tests++; if (res !== FIPS_OUT) begin n_fail++; $display("FAIL fwd_fips: got %h expected %h", res, FIPS_OUT); end
    release_out();
    n_tests++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL fwd_handoff: got valid=%b ready=%b expected valid=0 ready=1", valid_o, ready_o); end
  endtask

  task automatic test_inverse();
    logic [127:0] res;
    int lat;
    run_block(FIPS_OUT, 1'b0, res, lat);
    n_tests++; if (res !== FIPS_IN) begin n_fail++; $display("FAIL inv_fips: got %h expected %h", res, FIPS_IN); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL inv_latency: got %0d expected 4", lat); end
    release_out();
    run_block({16{8'h63}}, 1'b0, res, lat);
    n_tests++; if (res !== 128'h0) begin n_fail++; $display("FAIL inv_all63: got %h expected 0", res); end
    release_out();
    run_block(128'h0, 1'b1, res, lat);
    n_tests++; if (res !== {16{8'h63}}) begin n_fail++; $display("FAIL fwd_zero: got %h expected %h", res, {16{8'h63}}); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    run_block(FIPS_IN, 1'b1, res, lat);
    n_tests++; if (res !== FIPS_OUT || lat != 4) begin n_fail++; $display("FAIL bp_initial: got %h lat %0d expected %h lat 4", res, lat, FIPS_OUT); end
    for (int i = 0; i < 10; i++) begin
      valid_i    = i[0];
      block_i    = {$urandom, $urandom, $urandom, $urandom};
      fwd_ninv_i = ~fwd_ninv_i;
      @(posedge clk_i); #1;
      n_tests++;
      if (block_o !== FIPS_OUT || valid_o !== 1'b1 || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got block=%h valid=%b ready=%b expected block=%h valid=1 ready=0",
                 i, block_o, valid_o, ready_o, FIPS_OUT);
      end
    end
    valid_i = 1'b0;
    release_out();
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid: got %b expected 0", valid_o); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_after_ready: got %b expected 1", ready_o); end
  endtask

  task automatic test_mode_latch();
    int lat;
    lat = -1;
    block_i = FIPS_IN; fwd_ninv_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0; fwd_ninv_i = 1'b0; block_i = 128'hffff_0000_1234_5678_9abc_def0_5555_aaaa;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) begin
        lat = i;
        break;
      end
    end
    n_tests++; if (block_o !== FIPS_OUT || lat != 4) begin n_fail++; $display("FAIL mode_latch: got %h lat %0d expected %h lat 4", block_o, lat, FIPS_OUT); end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    logic [127:0] blks [6];
    logic         modes [6];
    logic [127:0] cap;
    logic [127:0] e;
    logic         acc;
    logic         xfer;
    int           sent;
    int           got;
    int           last_t;
    for (int i = 0; i < 6; i++) begin
      blks[i]  = {$urandom, $urandom, $urandom, $urandom};
      modes[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; last_t = -1;
    block_i = blks[0]; fwd_ninv_i = modes[0]; valid_i = 1'b1; ready_i = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      acc  = valid_i && ready_o;
      xfer = valid_o && ready_i;
      cap  = block_o;
      @(posedge clk_i); #1;
      if (acc) begin
        exp_q.push_back(model(blks[sent], modes[sent]));
        sent++;
        if (sent < 6) begin
          block_i = blks[sent]; fwd_ninv_i = modes[sent];
        end else begin
          valid_i = 1'b0;
        end
      end
      if (xfer) begin
        e = 128'h0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_tests++;
        if (cap !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, cap, e); end
        if (last_t >= 0) begin
          n_tests++;
          if (cyc - last_t != 6) begin n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected 6", got, cyc - last_t); end
        end
        last_t = cyc;
        got++;
      end
    end
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected 6", got); end
    valid_i = 1'b0; ready_i = 1'b0;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_mode_latch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
